// File: rtl/galaxian_loader_pkg.sv
// Shared definitions for the Galaxian ROM download path: region map,
// region identifiers and loader FSM states.
package galaxian_loader_pkg;

  // Download-stream byte addresses bounding each ROM region.
  localparam logic [24:0] PGM_BASE   = 25'h000_0000;
  localparam logic [24:0] K1_BASE    = 25'h000_4000;
  localparam logic [24:0] H1_BASE    = 25'h000_5000;
  localparam logic [24:0] PROM_BASE  = 25'h000_6000;
  localparam logic [24:0] PROM_LIMIT = 25'h000_6020;

  localparam int NUM_REGIONS = 4;

  // Encodings 0..3 double as the bit index in the region mask.
  typedef enum logic [2:0] {
    REG_PGM  = 3'd0,
    REG_1K   = 3'd1,
    REG_1H   = 3'd2,
    REG_PROM = 3'd3,
    REG_NONE = 3'd4
  } region_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_FAIL = 3'd4
  } state_t;

endpackage

// File: rtl/galaxian_rom_decode.sv
// Combinational map from a download byte address to its ROM region and
// the region-relative offset (zero when the address falls outside every region).
module galaxian_rom_decode
  import galaxian_loader_pkg::*;
(
  input  logic [24:0] addr,
  output region_t     region,
  output logic [13:0] offset
);

  always_comb begin
    region = REG_NONE;
    offset = '0;
    if (addr < K1_BASE) begin
      region = REG_PGM;
      offset = 14'(addr - PGM_BASE);
    end else if (addr < H1_BASE) begin
      region = REG_1K;
      offset = 14'(addr - K1_BASE);
    end else if (addr < PROM_BASE) begin
      region = REG_1H;
      offset = 14'(addr - H1_BASE);
    end else if (addr < PROM_LIMIT) begin
      region = REG_PROM;
      offset = 14'(addr - PROM_BASE);
    end
  end

endmodule

// File: rtl/galaxian_rom_loader.sv
// Routes the data_io ROM download into the Galaxian core ROMs and keeps the core
// in reset until every region is loaded. GALAXIAN_ROM_CHECKSUM_EN adds rom_sum/exp_sum gating.
module galaxian_rom_loader
  import galaxian_loader_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 256,
  parameter logic [7:0]  ROM_INDEX   = 8'd0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
`ifdef GALAXIAN_ROM_CHECKSUM_EN
  input  logic [15:0] exp_sum,
  output logic [15:0] rom_sum,
`endif
  output logic [13:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        pgm_we,
  output logic        gfx1k_we,
  output logic        gfx1h_we,
  output logic        prom_we,
  output logic        core_reset,
  output logic        rom_valid,
  output logic        dl_error
);

  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [3:0]  we_reg;
  logic [3:0]  mask_reg;
  logic [13:0] rom_addr_reg;
  logic [7:0]  rom_data_reg;
  logic        dl_error_reg;
  logic [15:0] hold_cnt_reg;

  region_t     dec_region;
  logic [13:0] dec_offset;
  logic [3:0]  hit;
  logic        rom_start;
  logic        wr_accept;
  logic        in_range;
  logic        load_entry;
  logic        sum_ok;
  logic        images_ok;

  galaxian_rom_decode u_decode (
    .addr   (ioctl_addr),
    .region (dec_region),
    .offset (dec_offset)
  );

  // Only the ROM slot counts; other indices never touch state or strobes.
  assign rom_start  = ioctl_download && (ioctl_index == ROM_INDEX);
  assign wr_accept  = (state_reg == ST_LOAD) && ioctl_wr && (ioctl_index == ROM_INDEX);
  assign in_range   = (dec_region != REG_NONE);
  assign load_entry = (state_next == ST_LOAD) && (state_reg != ST_LOAD);

  generate
    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_hit
      assign hit[gi] = wr_accept && (dec_region == region_t'(3'(gi)));
    end
  endgenerate

`ifdef GALAXIAN_ROM_CHECKSUM_EN
  logic [15:0] sum_reg;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sum_reg <= '0;
    end else if (load_entry) begin
      sum_reg <= '0;
    end else if (wr_accept && in_range) begin
      sum_reg <= sum_reg + 16'(ioctl_dout);
    end
  end

  assign rom_sum = sum_reg;
  assign sum_ok  = (sum_reg == exp_sum);
`else
  assign sum_ok = 1'b1;
`endif

  assign images_ok = (mask_reg == 4'b1111) && !dl_error_reg && sum_ok;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (rom_start) state_next = ST_LOAD;
      ST_LOAD: if (!ioctl_download) state_next = ST_HOLD;
      ST_HOLD: begin
        if (rom_start) begin
          state_next = ST_LOAD;
        end else if (hold_cnt_reg == '0) begin
          state_next = images_ok ? ST_RUN : ST_FAIL;
        end
      end
      ST_RUN:  if (rom_start) state_next = ST_LOAD;
      ST_FAIL: if (rom_start) state_next = ST_LOAD;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    core_reset = 1'b1;
    rom_valid  = 1'b0;
    if (state_reg == ST_RUN) begin
      core_reset = 1'b0;
      rom_valid  = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      we_reg       <= '0;
      mask_reg     <= '0;
      rom_addr_reg <= '0;
      rom_data_reg <= '0;
      dl_error_reg <= 1'b0;
      hold_cnt_reg <= '0;
    end else begin
      we_reg <= hit;
      if (wr_accept && in_range) begin
        rom_addr_reg <= dec_offset;
        rom_data_reg <= ioctl_dout;
      end
      // Entry into LOAD and accepted writes never coincide: writes need LOAD already.
      if (load_entry) begin
        mask_reg     <= '0;
        dl_error_reg <= 1'b0;
      end else if (wr_accept) begin
        mask_reg <= mask_reg | hit;
        if (!in_range) begin
          dl_error_reg <= 1'b1;
        end
      end
      if ((state_reg == ST_LOAD) && (state_next == ST_HOLD)) begin
        hold_cnt_reg <= HOLD_LOAD;
      end else if ((state_reg == ST_HOLD) && (hold_cnt_reg != '0)) begin
        hold_cnt_reg <= hold_cnt_reg - 16'd1;
      end
    end
  end

  assign pgm_we   = we_reg[REG_PGM];
  assign gfx1k_we = we_reg[REG_1K];
  assign gfx1h_we = we_reg[REG_1H];
  assign prom_we  = we_reg[REG_PROM];
  assign rom_addr = rom_addr_reg;
  assign rom_data = rom_data_reg;
  assign dl_error = dl_error_reg;

endmodule

// File: tb/tb_galaxian_rom_loader.sv
// Directed bench for galaxian_rom_loader: full/partial/erroneous loads, index
// filtering, reset abort, and the GALAXIAN_ROM_CHECKSUM_EN sum when defined.
`timescale 1ns/1ps
module tb_galaxian_rom_loader;

  localparam int HOLD = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [13:0] rom_addr;
  logic [7:0]  rom_data;
  logic        pgm_we, gfx1k_we, gfx1h_we, prom_we;
  logic        core_reset, rom_valid, dl_error;
`ifdef GALAXIAN_ROM_CHECKSUM_EN
  logic [15:0] exp_sum_v = 16'd53744;
  logic [15:0] rom_sum;
`endif

  always #5 clk = ~clk;

  galaxian_rom_loader #(.HOLD_CYCLES(HOLD), .ROM_INDEX(8'd0)) dut (
    .clk_sys        (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
`ifdef GALAXIAN_ROM_CHECKSUM_EN
    .exp_sum        (exp_sum_v),
    .rom_sum        (rom_sum),
`endif
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .pgm_we         (pgm_we),
    .gfx1k_we       (gfx1k_we),
    .gfx1h_we       (gfx1h_we),
    .prom_we        (prom_we),
    .core_reset     (core_reset),
    .rom_valid      (rom_valid),
    .dl_error       (dl_error)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Strobe monitor, sampled on the falling edge.
  int          cnt_pgm, cnt_1k, cnt_1h, cnt_prom, align_err, excl_err;
  logic [13:0] last_addr [4];
  bit          data_is_addr = 1'b1;

  always @(negedge clk) begin
    if ($countones({pgm_we, gfx1k_we, gfx1h_we, prom_we}) > 1) excl_err++;
    if (pgm_we)   begin cnt_pgm++;  last_addr[0] = rom_addr; end
    if (gfx1k_we) begin cnt_1k++;   last_addr[1] = rom_addr; end
    if (gfx1h_we) begin cnt_1h++;   last_addr[2] = rom_addr; end
    if (prom_we)  begin cnt_prom++; last_addr[3] = rom_addr; end
    if (data_is_addr && (pgm_we | gfx1k_we | gfx1h_we | prom_we) && rom_data != rom_addr[7:0])
      align_err++;
  end

  task automatic clr_counts;
    cnt_pgm = 0; cnt_1k = 0; cnt_1h = 0; cnt_prom = 0; align_err = 0; excl_err = 0;
    for (int i = 0; i < 4; i++) last_addr[i] = '0;
  endtask

  // First and last byte of every region; data is the low address byte.
  logic [24:0] sparse_tab [8] = '{25'h0000, 25'h3FFF, 25'h4000, 25'h4FFF,
                                  25'h5000, 25'h5FFF, 25'h6000, 25'h601F};

  task automatic start_dl(input logic [7:0] idx);
    @(negedge clk);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
  endtask

  task automatic write_sparse(input int first, input int last, input bit bad);
    for (int i = first; i <= last; i++) wr_byte(sparse_tab[i], sparse_tab[i][7:0]);
    if (bad) wr_byte(25'h6020, 8'h20);
  endtask

  // Drops download (optionally with a final write in the same cycle) and counts
  // cycles from the first edge sampling download low until core_reset falls; -1 if never.
  task automatic end_and_wait(input bit with_wr, input logic [24:0] a, input logic [7:0] d,
                              output int cycles);
    @(negedge clk);
    ioctl_download = 1'b0;
    ioctl_wr       = with_wr;
    ioctl_addr     = a;
    ioctl_dout     = d;
    cycles = -1;
    for (int n = 1; n <= HOLD + 20; n++) begin
      @(negedge clk);
      ioctl_wr = 1'b0;
      if (!core_reset) begin
        cycles = n - 1;
        break;
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    clr_counts();
    repeat (3) @(negedge clk);
    check("rst_strobes", int'({pgm_we, gfx1k_we, gfx1h_we, prom_we}), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_rom_data", int'(rom_data), 0);
    check("rst_core_reset", int'(core_reset), 1);
    check("rst_rom_valid", int'(rom_valid), 0);
    check("rst_dl_error", int'(dl_error), 0);
    reset = 1'b0;

    // Other index from IDLE: nothing happens.
    clr_counts();
    start_dl(8'd1);
    write_sparse(0, 7, 1'b0);
    end_and_wait(1'b0, '0, '0, cyc);
    check("idx_idle_strobes", cnt_pgm + cnt_1k + cnt_1h + cnt_prom, 0);
    check("idx_idle_release", cyc, -1);
    check("idx_idle_valid", int'(rom_valid), 0);

    // Full load, last byte written in the cycle download falls.
    clr_counts();
    start_dl(8'd0);
    for (int a = 0; a < 'h601F; a++) wr_byte(25'(a), 8'(a));
    end_and_wait(1'b1, 25'h601F, 8'h1F, cyc);
    check("full_pgm_cnt", cnt_pgm, 16384);
    check("full_1k_cnt", cnt_1k, 4096);
    check("full_1h_cnt", cnt_1h, 4096);
    check("full_prom_cnt", cnt_prom, 32);
    check("full_align", align_err, 0);
    check("full_exclusive", excl_err, 0);
    check("full_hold_cycles", cyc, HOLD);
    check("full_rom_valid", int'(rom_valid), 1);
    check("full_dl_error", int'(dl_error), 0);
    check("full_prom_last", int'(last_addr[3]), 'h1F);

    // Other index from RUN: core stays running.
    clr_counts();
    start_dl(8'd1);
    write_sparse(0, 7, 1'b0);
    @(negedge clk);
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    repeat (HOLD + 5) @(negedge clk);
    check("idx_run_strobes", cnt_pgm + cnt_1k + cnt_1h + cnt_prom, 0);
    check("idx_run_core_reset", int'(core_reset), 0);

    // New ROM download from RUN, then PROM missing.
    clr_counts();
    start_dl(8'd0);
    @(negedge clk);
    check("reload_core_reset", int'(core_reset), 1);
    check("reload_rom_valid", int'(rom_valid), 0);
    write_sparse(0, 5, 1'b0);
    end_and_wait(1'b0, '0, '0, cyc);
    check("noprom_release", cyc, -1);
    check("noprom_pgm_cnt", cnt_pgm, 2);
    check("noprom_prom_cnt", cnt_prom, 0);
    check("noprom_rom_valid", int'(rom_valid), 0);

    // Out-of-range byte: no strobe, sticky error, FAIL.
    clr_counts();
    start_dl(8'd0);
    write_sparse(0, 7, 1'b1);
    end_and_wait(1'b0, '0, '0, cyc);
    check("oor_prom_cnt", cnt_prom, 2);
    check("oor_dl_error", int'(dl_error), 1);
    check("oor_release", cyc, -1);
    check("oor_rom_valid", int'(rom_valid), 0);

    // Clean reload recovers.
    clr_counts();
`ifdef GALAXIAN_ROM_CHECKSUM_EN
    exp_sum_v = 16'd796;
`endif
    start_dl(8'd0);
    write_sparse(0, 7, 1'b0);
    end_and_wait(1'b0, '0, '0, cyc);
    check("clean_hold_cycles", cyc, HOLD);
    check("clean_rom_valid", int'(rom_valid), 1);
    check("clean_dl_error", int'(dl_error), 0);
    check("clean_pgm_last", int'(last_addr[0]), 'h3FFF);
    check("clean_1k_last", int'(last_addr[1]), 'h0FFF);
    check("clean_1h_last", int'(last_addr[2]), 'h0FFF);
    check("clean_rom_data", int'(rom_data), 'h1F);

    // Reset during LOAD at 0x2000.
    start_dl(8'd0);
    wr_byte(25'h1FFF, 8'hFF);
    wr_byte(25'h2000, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    @(negedge clk);
    check("abort_core_reset", int'(core_reset), 1);
    check("abort_rom_valid", int'(rom_valid), 0);
    reset = 1'b0;
    repeat (HOLD + 5) @(negedge clk);
    check("abort_idle_core_reset", int'(core_reset), 1);

    // PROM alone after the abort is not enough.
    start_dl(8'd0);
    write_sparse(6, 7, 1'b0);
    end_and_wait(1'b0, '0, '0, cyc);
    check("partial_release", cyc, -1);

    start_dl(8'd0);
    write_sparse(0, 7, 1'b0);
    end_and_wait(1'b0, '0, '0, cyc);
    check("abort_reload_hold", cyc, HOLD);
    check("abort_reload_valid", int'(rom_valid), 1);

`ifdef GALAXIAN_ROM_CHECKSUM_EN
    // 0x01 everywhere except the PROM (0x10 + offset): 24576 + 1008.
    data_is_addr = 1'b0;
    exp_sum_v = 16'd25584;
    start_dl(8'd0);
    for (int a = 0; a < 'h601F; a++)
      wr_byte(25'(a), (a >= 'h6000) ? 8'(8'h10 + (a & 'h1F)) : 8'h01);
    end_and_wait(1'b1, 25'h601F, 8'h2F, cyc);
    check("sum_value", int'(rom_sum), 25584);
    check("sum_rom_valid", int'(rom_valid), 1);

    exp_sum_v = 16'd797;
    start_dl(8'd0);
    write_sparse(0, 7, 1'b0);
    end_and_wait(1'b0, '0, '0, cyc);
    check("sum_sparse_value", int'(rom_sum), 796);
    check("sum_mismatch_release", cyc, -1);
    check("sum_mismatch_valid", int'(rom_valid), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
